uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an integrated transmit FIFO and a valid/ready byte interface. It supersedes the fixed 8N1 single-byte transmitter. It sits between the system-side command/telemetry logic of the dual-DA system and the board TXD pin. Character width, stop bits, parity and FIFO depth are set per instance, and queued characters are sent back-to-back with no idle gap.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync_fifo.sv | 89 ++++++++
 rtl/uart_tx_fifo.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the FIFO-fed UART transmitter:
//   - uart_state_e : transmitter state encoding
//   - baud_div()   : clock cycles per bit (integer-truncated quotient)
//   - legality limits for the character width, stop bits and baud divisor
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 8;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;
  localparam int BAUD_CNT_MIN  = 4;

  function automatic int baud_div(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO holding characters waiting to be transmitted.
// Pointers carry one extra wrap bit (modulo 2*DEPTH); full, empty and level
// are registered.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   i_wr_en     : write request (ignored while full)
//   i_wr_data   : character to store
//   i_rd_en     : pop request (ignored while empty)
//   o_rd_data   : head character, valid while !o_empty
//   o_full      : DEPTH entries stored
//   o_empty     : no entries stored
//   o_level     : number of entries stored
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      r_level;
  logic             r_full;
  logic             r_empty;

  logic             w_wr;
  logic             w_rd;
  logic [AW:0]      w_level_next;

  assign w_wr = i_wr_en && !r_full;
  assign w_rd = i_rd_en && !r_empty;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_level_next = r_level;
    case ({w_wr, w_rd})
      2'b10:   w_level_next = r_level + LVL_ONE;
      2'b01:   w_level_next = r_level - LVL_ONE;
      default: w_level_next = r_level;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + LVL_ONE;
      if (w_rd) r_rd_ptr <= r_rd_ptr + LVL_ONE;
      r_level <= w_level_next;
      r_full  <= (w_level_next == LVL_FULL);
      r_empty <= (w_level_next == '0);
    end
  end

  // NOTE: the storage array has no reset; contents are only read once the
  // pointers say an entry was written, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full    = r_full;
  assign o_empty   = r_empty;
  assign o_level   = r_level;

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Parametrised UART transmitter fed by a FIFO with a valid/ready byte port.
// Queued characters go out back-to-back with no idle gap between frames.
// Build option: define UART_TX_PARITY_EN to add a parity bit after the data
// bits (PARITY_ODD selects the sense); without it frames are xN1/xN2.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   tx_valid      : character offered on tx_data
//   tx_data       : character, sent LSB first
//   tx_ready      : FIFO can accept a write (!full)
//   uart_txd      : registered serial output, idle high
//   uart_tx_busy  : a frame is in progress
//   fifo_level    : queued characters, excluding the one being sent
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 20000000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  import uart_pkg::*;

  localparam int BAUD_CNT_MAX = baud_div(CLK_FREQ, UART_BPS);
  localparam int BAUD_W       = $clog2(BAUD_CNT_MAX);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT_MAX - 1);
  localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
      STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
      BAUD_CNT_MAX < BAUD_CNT_MIN || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_error
    $error("uart_tx_fifo: illegal parameter combination");
  end

  uart_state_e           r_state;
  uart_state_e           w_next_state;
  logic [BAUD_W-1:0]     r_baud_cnt;
  logic [2:0]            r_bit_cnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_txd;
  logic                  r_busy;
  logic                  r_fifo_avail;
  logic                  w_txd_next;
  logic                  w_pop;
  logic                  w_shift_en;
  logic                  w_baud_end;
  logic [DATA_BITS-1:0]  w_fifo_data;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic                  r_parity;
`endif

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (tx_valid),
    .i_wr_data (tx_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_data),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_level   (fifo_level)
  );

  assign w_baud_end = (r_baud_cnt == BAUD_LAST);

  // The next-state logic works from a registered copy of "FIFO not empty":
  // a write becomes a frame start two edges after it is accepted, and a write
  // landing in the final STOP cycle costs exactly one IDLE cycle.
  always_comb begin
    w_next_state = r_state;
    w_txd_next   = r_txd;
    w_pop        = 1'b0;
    w_shift_en   = 1'b0;
    case (r_state)
      IDLE: begin
        w_txd_next = 1'b1;
        if (r_fifo_avail) begin
          w_pop        = 1'b1;
          w_next_state = START;
          w_txd_next   = 1'b0;
        end
      end
      START: begin
        if (w_baud_end) begin
          w_next_state = DATA;
          w_txd_next   = r_shift[0];
        end
      end
      DATA: begin
        if (w_baud_end) begin
          if (r_bit_cnt == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
            w_next_state = PARITY;
            w_txd_next   = r_parity;
`else
            w_next_state = STOP;
            w_txd_next   = 1'b1;
`endif
          end else begin
            // Output the bit that becomes r_shift[0] after this edge's shift.
            w_shift_en = 1'b1;
            w_txd_next = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_baud_end) begin
          w_next_state = STOP;
          w_txd_next   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (w_baud_end && r_bit_cnt == STOP_LAST) begin
          if (r_fifo_avail) begin
            w_pop        = 1'b1;
            w_next_state = START;
            w_txd_next   = 1'b0;
          end else begin
            w_next_state = IDLE;
            w_txd_next   = 1'b1;
          end
        end
      end
      default: begin
        w_next_state = IDLE;
        w_txd_next   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_baud_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_txd        <= 1'b1;
      r_busy       <= 1'b0;
      r_fifo_avail <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_state      <= w_next_state;
      r_txd        <= w_txd_next;
      r_busy       <= (w_next_state != IDLE);
      r_fifo_avail <= !w_fifo_empty;

      if (w_next_state == IDLE || w_pop || w_baud_end) r_baud_cnt <= '0;
      else                                             r_baud_cnt <= r_baud_cnt + 1'b1;

      if (w_pop) begin
        r_shift   <= w_fifo_data;
        r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
        r_parity  <= (^w_fifo_data) ^ (PARITY_ODD != 0);
`endif
      end else if (w_baud_end) begin
        if (w_shift_en) begin
          r_shift   <= r_shift >> 1;
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end else if (r_state != w_next_state) begin
          // Every state change reuses the bit counter from zero.
          r_bit_cnt <= '0;
        end else if (r_state == STOP) begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
      end
    end
  end

  assign tx_ready     = !w_fifo_full;
  assign uart_txd     = r_txd;
  assign uart_tx_busy = r_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Two instances: A is the default 8x1 build (depth 16), B is 5-bit, 2 stop
// bits, odd parity sense, depth 4. Stimulus pushes expected characters into
// per-instance queues; a serial monitor per instance decodes uart_txd mid-bit
// and pops/compares. Timing and flag checks run inline in the stimulus thread.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 20000000;
  localparam int UART_BPS = 115200;
  localparam int BAUD     = 173;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME_A = (1 + 8 + P + 1) * BAUD;
  localparam int FRAME_B = (1 + 5 + P + 2) * BAUD;
  localparam int PODD_A  = 0;
  localparam int PODD_B  = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       va, ra, txa, busya;
  logic [7:0] da;
  logic [4:0] lvla;
  logic       vb, rb, txb, busyb;
  logic [4:0] db;
  logic [2:0] lvlb;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(8),
    .STOP_BITS(1), .PARITY_ODD(PODD_A), .FIFO_DEPTH(16)
  ) u_dut_a (
    .clk(clk), .rst(rst), .tx_valid(va), .tx_data(da), .tx_ready(ra),
    .uart_txd(txa), .uart_tx_busy(busya), .fifo_level(lvla)
  );

  uart_tx_fifo #(
    .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(5),
    .STOP_BITS(2), .PARITY_ODD(PODD_B), .FIFO_DEPTH(4)
  ) u_dut_b (
    .clk(clk), .rst(rst), .tx_valid(vb), .tx_data(db), .tx_ready(rb),
    .uart_txd(txb), .uart_tx_busy(busyb), .fifo_level(lvlb)
  );

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  logic [7:0] bp_vec [20] = '{8'h00, 8'hFF, 8'h07, 8'h80, 8'h01, 8'hA5, 8'h5A, 8'h3C,
                              8'hC3, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE,
                              8'hF0, 8'h0F, 8'h69, 8'h96};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, req);
    end
  endtask

  function automatic logic line_of(input int w);
    return (w != 0) ? txb : txa;
  endfunction

  // Serial decoder: finds the falling start edge, samples every bit mid-way.
  task automatic monitor(input int w, input int nbits, input int nstop, input int podd);
    logic       prev, v, abort, par_got;
    logic [7:0] got, e;
    int         nslots, wait_n;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
        continue;
      end
      v = line_of(w);
      if (prev && !v) begin
        abort   = 1'b0;
        got     = '0;
        par_got = 1'b0;
        nslots  = 1 + nbits + P + nstop;
        for (int b = 0; b < nslots; b++) begin
          wait_n = (b == 0) ? BAUD / 2 : BAUD;
          for (int c = 0; c < wait_n; c++) begin
            @(negedge clk);
            if (rst) abort = 1'b1;
          end
          if (abort) break;
          v = line_of(w);
          if (b == 0)                      check($sformatf("start_bit%0d", w), {31'd0, v}, 32'd0);
          else if (b <= nbits)             got[b-1] = v;
          else if (P == 1 && b == nbits+1) par_got = v;
          else                             check($sformatf("stop_bit%0d", w), {31'd0, v}, 32'd1);
        end
        if (!abort) begin
          if (((w != 0) ? exp_b.size() : exp_a.size()) == 0) begin
            total++;
            bad++;
            $display("FAIL frame_unexpected%0d: got %0h, wanted no frame", w, got);
          end else begin
            e = (w != 0) ? exp_b.pop_front() : exp_a.pop_front();
            check($sformatf("data%0d", w), {24'd0, got}, {24'd0, e});
`ifdef UART_TX_PARITY_EN
            check($sformatf("parity%0d", w), {31'd0, par_got}, {31'd0, (^e) ^ podd[0]});
`endif
          end
        end
        prev = 1'b1;
      end else begin
        prev = v;
      end
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [7:0] b);
    va = 1'b1;
    da = b;
    tick();
    va = 1'b0;
  endtask

  task automatic wait_idle_a(input int limit);
    for (int i = 0; i < limit; i++) begin
      tick();
      if (!busya && lvla == 0) break;
    end
    check("idle_timeout", {31'd0, busya}, 32'd0);
  endtask

  int n;
  int idx;
  int first_full;
  logic acc;

  initial begin
    fork
      monitor(0, 8, 1, PODD_A);
      monitor(1, 5, 2, PODD_B);
    join_none

    rst = 1'b1; va = 1'b0; da = '0; vb = 1'b0; db = '0;
    tick(3);
    check("rst_txd",   {31'd0, txa},   32'd1);
    check("rst_busy",  {31'd0, busya}, 32'd0);
    check("rst_ready", {31'd0, ra},    32'd1);
    check("rst_level", {27'd0, lvla},  32'd0);
    check("rst_txd_b", {31'd0, txb},   32'd1);
    rst = 1'b0;
    tick(2);

    // Single frame, latency and busy width.
    exp_a.push_back(8'h55);
    write_a(8'h55);                                        // edge k
    check("lat_level_k",  {27'd0, lvla}, 32'd1);
    check("lat_txd_k",    {31'd0, txa},  32'd1);
    tick();                                                // k+1
    check("lat_txd_k1",   {31'd0, txa},  32'd1);
    tick();                                                // k+2
    check("lat_txd_k2",   {31'd0, txa},   32'd0);
    check("lat_busy_k2",  {31'd0, busya}, 32'd1);
    check("lat_level_k2", {27'd0, lvla},  32'd0);
    n = 1;
    for (int i = 0; i < FRAME_A + 100; i++) begin
      tick();
      if (!busya) break;
      n++;
    end
    check("busy_len", n, FRAME_A);
    tick(5);

    // Boundary: second write accepted on the edge opening the last STOP cycle.
    exp_a.push_back(8'h3C);
    write_a(8'h3C);                                        // edge k, start k+2
    tick(FRAME_A);                                         // edge k+FRAME
    exp_a.push_back(8'hC3);
    write_a(8'hC3);                                        // edge start+FRAME-1
    check("bnd_busy_last", {31'd0, busya}, 32'd1);
    check("bnd_level",     {27'd0, lvla},  32'd1);
    tick();
    check("bnd_idle_busy", {31'd0, busya}, 32'd0);
    check("bnd_idle_txd",  {31'd0, txa},   32'd1);
    tick();
    check("bnd_start_txd",  {31'd0, txa},   32'd0);
    check("bnd_start_busy", {31'd0, busya}, 32'd1);
    wait_idle_a(FRAME_A + 100);
    tick(5);

    // Backpressure: tx_valid held high across 20 characters.
    idx = 0;
    first_full = -1;
    va = 1'b1;
    da = bp_vec[0];
    for (int c = 0; c < 40000 && idx < 20; c++) begin
      acc = ra;
      tick();
      if (acc) begin
        exp_a.push_back(bp_vec[idx]);
        idx++;
        if (idx < 20) da = bp_vec[idx];
        else          va = 1'b0;
      end
      if (!ra && first_full < 0) begin
        first_full = idx;
        check("bp_full_level", {27'd0, lvla}, 32'd16);
      end
    end
    va = 1'b0;
    check("bp_accept_before_full", first_full, 32'd17);
    check("bp_all_accepted", idx, 32'd20);
    wait_idle_a(20 * FRAME_A + 1000);
    tick(5);
    check("sb_a_drained", exp_a.size(), 32'd0);

    // Reset during data bit 3, then a fresh character.
    write_a(8'h5A);                                        // edge k, start k+2
    write_a(8'h11);
    write_a(8'h22);                                        // edge k+2
    tick(4 * BAUD + 80);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_txd",   {31'd0, txa},   32'd1);
    check("mrst_busy",  {31'd0, busya}, 32'd0);
    check("mrst_level", {27'd0, lvla},  32'd0);
    check("mrst_ready", {31'd0, ra},    32'd1);
    tick(2);
    rst = 1'b0;
    tick(2);
    exp_a.push_back(8'hA3);
    write_a(8'hA3);
    wait_idle_a(FRAME_A + 100);
    tick(5);
    check("sb_a_after_rst", exp_a.size(), 32'd0);

    // Instance B: two queued 5-bit characters, 2 stop bits, no gap.
    exp_b.push_back(8'h1F);
    exp_b.push_back(8'h07);
    vb = 1'b1;
    db = 5'h1F;
    tick();                                                // edge k
    db = 5'h07;
    tick();                                                // edge k+1
    vb = 1'b0;
    tick();                                                // edge k+2
    check("b_start_txd",  {31'd0, txb},   32'd0);
    check("b_start_busy", {31'd0, busyb}, 32'd1);
    n = 1;
    for (int i = 0; i < 2 * FRAME_B + 100; i++) begin
      tick();
      if (!busyb) break;
      n++;
    end
    check("b_busy_len_two_frames", n, 2 * FRAME_B);
    tick(10);
    check("sb_b_drained", exp_b.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
